// File: rtl/vehicle_demand_sensor_if.sv
// Side-road demand sensor signal bundle.
// The slave modport is the sensor block itself; the master modport is the
// environment that drives the loop detector and the controller light state.
interface vehicle_demand_sensor_if #(
  parameter int CNT_W = 4
);
  logic             sensor_raw;
  logic [1:0]       ew;
  logic             X;
  logic [CNT_W-1:0] q_cnt;
  logic             arrival;
  logic             sat_flag;

  modport master (
    output sensor_raw,
    output ew,
    input  X,
    input  q_cnt,
    input  arrival,
    input  sat_flag
  );

  modport slave (
    input  sensor_raw,
    input  ew,
    output X,
    output q_cnt,
    output arrival,
    output sat_flag
  );
endinterface

// File: rtl/vehicle_demand_sensor.sv
// vehicle_demand_sensor: conditions the raw side-road loop detector into the
// intersection controller's X demand input. The detector is synchronised,
// debounced and turned into one arrival pulse per vehicle; a saturating queue
// counter tracks waiting vehicles and is drained during east-west green.
// Optional macro MAX_GREEN_EN bounds the SERVE phase to MAX_GREEN cycles and
// adds a HOLDOFF state that drops X until the controller leaves green.
module vehicle_demand_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int DRAIN_CYCLES    = 8,
  parameter int MAX_GREEN       = 32
) (
  input  logic                    clock,
  input  logic                    clear_n,
  vehicle_demand_sensor_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [1:0]       EW_GREEN = 2'd2;
  localparam logic [CNT_W-1:0] Q_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] Q_ZERO   = {CNT_W{1'b0}};

`ifdef MAX_GREEN_EN
  localparam int SV_W = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVE   = 2'd2
`ifdef MAX_GREEN_EN
    ,
    HOLDOFF = 2'd3
`endif
  } state_t;

  state_t           state_r;
  logic             s1_r;
  logic             s2_r;
  logic             det_r;
  logic             det_prev_r;
  logic [DB_W-1:0]  db_cnt_r;
  logic [DR_W-1:0]  drain_r;
  logic [CNT_W-1:0] q_cnt_r;
  logic             arrival_r;
  logic             sat_r;
  logic             x_r;
`ifdef MAX_GREEN_EN
  logic [SV_W-1:0]  serve_cnt_r;
  logic             max_green_s;
`endif

  logic green_s;
  logic in_serve_s;
  logic drain_tc_s;
  logic q_zero_s;
  logic inc_s;
  logic dec_s;

  // Decode green, drain terminal count and queue increment/decrement requests.
  always_comb begin
    green_s    = (bus.ew == EW_GREEN);
    in_serve_s = (state_r == SERVE);
    drain_tc_s = in_serve_s && green_s && (drain_r == DR_W'(DRAIN_CYCLES - 1));
    q_zero_s   = (q_cnt_r == Q_ZERO);
    inc_s      = det_r & ~det_prev_r;
    dec_s      = drain_tc_s & ~q_zero_s;
  end

`ifdef MAX_GREEN_EN
  // Flag the last permitted SERVE cycle.
  always_comb begin
    max_green_s = (serve_cnt_r == SV_W'(MAX_GREEN - 1));
  end
`endif

  // Two-flop synchroniser for the asynchronous detector level.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= bus.sensor_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce: det flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      det_r    <= 1'b0;
      db_cnt_r <= {DB_W{1'b0}};
    end else if (s2_r == det_r) begin
      db_cnt_r <= {DB_W{1'b0}};
    end else if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      det_r    <= ~det_r;
      db_cnt_r <= {DB_W{1'b0}};
    end else begin
      db_cnt_r <= db_cnt_r + DB_W'(1);
    end
  end

  // Rising-edge detect on det; arrival is registered alongside the queue update.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      det_prev_r <= 1'b0;
      arrival_r  <= 1'b0;
    end else begin
      det_prev_r <= det_r;
      arrival_r  <= inc_s;
    end
  end

  // Saturating queue counter; a dropped arrival sets the sticky saturation flag.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      q_cnt_r <= Q_ZERO;
      sat_r   <= 1'b0;
    end else if (inc_s && !dec_s) begin
      if (q_cnt_r == Q_MAX) begin
        sat_r <= 1'b1;
      end else begin
        q_cnt_r <= q_cnt_r + CNT_W'(1);
      end
    end else if (dec_s && !inc_s) begin
      q_cnt_r <= q_cnt_r - CNT_W'(1);
    end else begin
      q_cnt_r <= q_cnt_r;
    end
  end

  // Drain timer: advances only in SERVE during green, wraps at its terminal count.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      drain_r <= {DR_W{1'b0}};
    end else if (!in_serve_s) begin
      drain_r <= {DR_W{1'b0}};
    end else if (drain_tc_s) begin
      drain_r <= {DR_W{1'b0}};
    end else if (green_s) begin
      drain_r <= drain_r + DR_W'(1);
    end else begin
      drain_r <= drain_r;
    end
  end

`ifdef MAX_GREEN_EN
  // SERVE-phase length counter used to cap east-west green.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      serve_cnt_r <= {SV_W{1'b0}};
    end else if (in_serve_s) begin
      serve_cnt_r <= serve_cnt_r + SV_W'(1);
    end else begin
      serve_cnt_r <= {SV_W{1'b0}};
    end
  end
`endif

  // Demand FSM; X is registered together with the state so it cannot glitch.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= IDLE;
      x_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!q_zero_s) begin
            state_r <= REQUEST;
            x_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
            x_r     <= 1'b0;
          end
        end
        REQUEST: begin
          if (green_s) begin
            state_r <= SERVE;
          end else begin
            state_r <= REQUEST;
          end
          x_r <= 1'b1;
        end
        SERVE: begin
          if (q_zero_s) begin
            state_r <= IDLE;
            x_r     <= 1'b0;
`ifdef MAX_GREEN_EN
          end else if (max_green_s) begin
            state_r <= HOLDOFF;
            x_r     <= 1'b0;
`endif
          end else if (!green_s) begin
            state_r <= REQUEST;
            x_r     <= 1'b1;
          end else begin
            state_r <= SERVE;
            x_r     <= 1'b1;
          end
        end
`ifdef MAX_GREEN_EN
        HOLDOFF: begin
          if (green_s) begin
            state_r <= HOLDOFF;
            x_r     <= 1'b0;
          end else if (!q_zero_s) begin
            state_r <= REQUEST;
            x_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
            x_r     <= 1'b0;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          x_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.X        = x_r;
  assign bus.q_cnt    = q_cnt_r;
  assign bus.arrival  = arrival_r;
  assign bus.sat_flag = sat_r;

endmodule

// File: tb/tb_vehicle_demand_sensor.sv
// Directed self-checking bench for vehicle_demand_sensor (default parameters).
// Each expected arrival is pushed to a scoreboard when the vehicle is driven;
// a monitor pops it when the DUT pulses arrival and checks q_cnt/sat_flag.
module tb_vehicle_demand_sensor;

  localparam int CNT_W = 4;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;

  always #5 clock = ~clock;

  vehicle_demand_sensor_if #(.CNT_W(CNT_W)) bus ();

  vehicle_demand_sensor #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (CNT_W),
    .DRAIN_CYCLES   (8),
    .MAX_GREEN      (32)
  ) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .bus    (bus)
  );

  typedef struct {
    int q;
    int sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   model_q = 0;
  int   model_sat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Model one debounced arrival; coincident_dec means a drain decrement lands on the same edge.
  task automatic expect_arrival(input bit coincident_dec);
    exp_t e;
    if (coincident_dec) begin
      model_q = model_q;
    end else if (model_q == 15) begin
      model_sat = 1;
    end else begin
      model_q = model_q + 1;
    end
    e.q   = model_q;
    e.sat = model_sat;
    sb.push_back(e);
  endtask

  task automatic vehicle();
    expect_arrival(1'b0);
    bus.sensor_raw = 1'b1;
    tick(8);
    bus.sensor_raw = 1'b0;
    tick(8);
  endtask

  // Scoreboard monitor: every arrival pulse must match a pushed expectation.
  always @(posedge clock) begin
    #1;
    if (clear_n && bus.arrival) begin
      if (sb.size() == 0) begin
        check("unexpected_arrival", 32'(bus.arrival), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("arr_q_cnt", 32'(bus.q_cnt), 32'(mon_e.q));
        check("arr_sat_flag", 32'(bus.sat_flag), 32'(mon_e.sat));
      end
    end
  end

  initial begin
    bus.sensor_raw = 1'b0;
    bus.ew         = 2'd0;
    clear_n        = 1'b0;
    #1;
    check("rst_X", 32'(bus.X), 32'd0);
    check("rst_q_cnt", 32'(bus.q_cnt), 32'd0);
    check("rst_arrival", 32'(bus.arrival), 32'd0);
    check("rst_sat_flag", 32'(bus.sat_flag), 32'd0);
    tick(2);
    clear_n = 1'b1;
    tick(3);

    // Glitch of 3 samples must not produce an arrival.
    bus.sensor_raw = 1'b1;
    tick(3);
    bus.sensor_raw = 1'b0;
    tick(12);
    check("glitch_q_cnt", 32'(bus.q_cnt), 32'd0);
    check("glitch_X", 32'(bus.X), 32'd0);

    // Single arrival latency: arrival/q_cnt at edge 7, X at edge 8.
    expect_arrival(1'b0);
    bus.sensor_raw = 1'b1;
    tick(6);
    check("e6_arrival", 32'(bus.arrival), 32'd0);
    check("e6_q_cnt", 32'(bus.q_cnt), 32'd0);
    tick(1);
    check("e7_arrival", 32'(bus.arrival), 32'd1);
    check("e7_q_cnt", 32'(bus.q_cnt), 32'd1);
    check("e7_X", 32'(bus.X), 32'd0);
    tick(1);
    check("e8_X", 32'(bus.X), 32'd1);
    check("e8_arrival", 32'(bus.arrival), 32'd0);
    bus.sensor_raw = 1'b0;
    tick(8);

    // Build a queue of 3, then drain under green with an arrival on the 2nd decrement.
    vehicle();
    vehicle();
    check("q3_q_cnt", 32'(bus.q_cnt), 32'd3);
    check("q3_X", 32'(bus.X), 32'd1);
    bus.ew = 2'd2;
    tick(1);
    tick(7);
    check("drain_e7_q", 32'(bus.q_cnt), 32'd3);
    tick(1);
    model_q = 2;
    check("drain_e8_q", 32'(bus.q_cnt), 32'd2);
    tick(1);
    bus.sensor_raw = 1'b1;
    expect_arrival(1'b1);
    tick(6);
    check("drain_e15_q", 32'(bus.q_cnt), 32'd2);
    tick(1);
    check("drain_e16_coincident_q", 32'(bus.q_cnt), 32'd2);
    tick(1);
    bus.sensor_raw = 1'b0;
    tick(7);
    check("drain_e24_q", 32'(bus.q_cnt), 32'd1);
    tick(8);
    model_q = 0;
    check("drain_e32_q", 32'(bus.q_cnt), 32'd0);
    check("drain_e32_X", 32'(bus.X), 32'd1);
    tick(1);
    check("drain_release_X", 32'(bus.X), 32'd0);
    bus.ew = 2'd0;
    tick(4);

    // Saturation: 16 arrivals with ew red.
    for (int i = 0; i < 16; i++) begin
      vehicle();
      if (i == 14) begin
        check("sat15_q", 32'(bus.q_cnt), 32'd15);
        check("sat15_flag", 32'(bus.sat_flag), 32'd0);
      end
    end
    check("sat16_q", 32'(bus.q_cnt), 32'd15);
    check("sat16_flag", 32'(bus.sat_flag), 32'd1);

    // Drain 12 vehicles to reach q_cnt=3 mid-SERVE, then reset asynchronously.
    bus.ew = 2'd2;
    tick(1);
    tick(96);
    check("pre_rst_q", 32'(bus.q_cnt), 32'd3);
    check("pre_rst_X", 32'(bus.X), 32'd1);
    check("pre_rst_sat", 32'(bus.sat_flag), 32'd1);
    #1;
    clear_n = 1'b0;
    #1;
    check("async_rst_X", 32'(bus.X), 32'd0);
    check("async_rst_q", 32'(bus.q_cnt), 32'd0);
    check("async_rst_arrival", 32'(bus.arrival), 32'd0);
    check("async_rst_sat", 32'(bus.sat_flag), 32'd0);
    model_q   = 0;
    model_sat = 0;
    tick(1);
    clear_n = 1'b1;
    tick(2);
    check("post_rst_X", 32'(bus.X), 32'd0);
    check("post_rst_q", 32'(bus.q_cnt), 32'd0);
    bus.ew = 2'd0;
    tick(2);

`ifdef MAX_GREEN_EN
    // Bounded green: 10 queued, SERVE capped at 32 cycles.
    for (int i = 0; i < 10; i++) begin
      vehicle();
    end
    bus.ew = 2'd2;
    tick(1);
    tick(31);
    check("mg_e31_X", 32'(bus.X), 32'd1);
    tick(1);
    check("mg_holdoff_X", 32'(bus.X), 32'd0);
    check("mg_holdoff_q", 32'(bus.q_cnt), 32'd6);
    bus.ew = 2'd1;
    tick(1);
    bus.ew = 2'd0;
    tick(1);
    check("mg_rerequest_X", 32'(bus.X), 32'd1);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
